// File: rtl/hack_pkg.sv
// Shared constants and FSM encoding for the shift-add multiplier.
package hack_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_STEP = 5'd15;

endpackage

// File: rtl/add16.sv
// Fixed-width 16-bit ripple adder with carry in/out; the multiplier's only adder.
module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {16'd0, cin};

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential unsigned 16x16->32 multiplier: one partial product per clock through add16.
module shift_add_mult16
  import hack_pkg::*;
#(
  parameter int WIDTH = hack_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  if (WIDTH != 16) begin : g_bad_width
    $error("shift_add_mult16: WIDTH must be 16, add16 is fixed width");
  end

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [4:0]           count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 overflow_q, overflow_d;
  logic                 ready_q, busy_q, done_q;
  logic                 accept;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  add16 u_add (
    .a    (hi_q),
    .b    (mcand_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    count_d    = count_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    if (accept) begin
      state_d    = ST_RUN;
      mcand_d    = a;
      hi_d       = '0;
      lo_d       = b;
      count_d    = 5'd0;
      product_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          // Carry out lands in hi[15]; the multiplier bit just used falls off lo[0].
          if (lo_q[0]) {hi_d, lo_d} = {add_cout, add_sum, lo_q[WIDTH-1:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
          count_d = count_q + 5'd1;
          if (count_q == LAST_STEP) begin
            state_d    = ST_DONE;
            product_d  = {hi_d, lo_d};
            overflow_d = |hi_d;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mcand_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      count_q    <= 5'd0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      count_q    <= count_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      ready_q    <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      busy_q     <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule
